// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: register file, forwarding, immediate/negate select, one output register.
// Latency: one cycle from accept to DATA1/DATA2/SELECT valid.
// Backpressure: IN_READY = !OUT_VALID || OUT_READY; a stalled operation holds its captured operands.
module alu_operand_stage #(
  parameter int WIDTH  = 8,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [ADDR_W-1:0] READREG1,
  input  logic [ADDR_W-1:0] READREG2,
  input  logic [WIDTH-1:0]  IMMEDIATE,
  input  logic              IMM_SEL,
  input  logic              NEG_SEL,
  input  logic [2:0]        ALUOP,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [WIDTH-1:0]  DATA1,
  output logic [WIDTH-1:0]  DATA2,
  output logic [2:0]        SELECT,
  input  logic              WRITEENABLE,
  input  logic [ADDR_W-1:0] WRITEREG,
  input  logic [WIDTH-1:0]  WRITEDATA
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [WIDTH-1:0] data2_q, data2_d;
  logic [2:0]       select_q, select_d;

  logic             accept;
  logic [WIDTH-1:0] r1, r2, s2, op2;

  assign IN_READY  = !valid_q || OUT_READY;
  assign accept    = IN_VALID && IN_READY;
  assign OUT_VALID = valid_q;
  assign DATA1     = data1_q;
  assign DATA2     = data2_q;
  assign SELECT    = select_q;

  // Register-file write port; independent of the operand handshake.
  always_comb begin
    regs_d = regs_q;
    if (WRITEENABLE) begin
      regs_d[WRITEREG] = WRITEDATA;
    end
  end

  // Register-file state; reset clears every entry.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Operand formation: write-first forwarding, immediate select, optional two's-complement negate.
  always_comb begin
    r1  = (WRITEENABLE && (WRITEREG == READREG1)) ? WRITEDATA : regs_q[READREG1];
    r2  = (WRITEENABLE && (WRITEREG == READREG2)) ? WRITEDATA : regs_q[READREG2];
    s2  = IMM_SEL ? IMMEDIATE : r2;
    op2 = NEG_SEL ? (~s2 + WIDTH'(1)) : s2;
  end

  // Output register next state: load on accept, drop valid on a bare consume, otherwise hold.
  always_comb begin
    valid_d  = valid_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    select_d = select_q;
    if (accept) begin
      valid_d  = 1'b1;
      data1_d  = r1;
      data2_d  = op2;
      select_d = ALUOP;
    end else if (valid_q && OUT_READY) begin
      valid_d  = 1'b0;
    end
  end

  // Output register state; reset discards any held operation.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q  <= 1'b0;
      data1_q  <= '0;
      data2_q  <= '0;
      select_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      select_q <= select_d;
    end
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch stage directly upstream of the 8-bit ALU.
- Contains the register file. Reads two source registers, selects an immediate in place of source 2 and optionally negates source 2 (two's complement, for SUB).
- Registers DATA1/DATA2/SELECT into one pipeline register with a valid/ready handshake toward the ALU.
- Accepts ALU write-back through a synchronous write port, with same-cycle forwarding into operand fetch.

Parameters:
- WIDTH, 8, data width of registers, operands and immediate.
- NREGS, 8, number of registers.
- ADDR_W, 3, register address width; NREGS == 2**ADDR_W.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  upstream has an operation to issue.
- IN_READY  output  1  stage can accept an operation this cycle.
- READREG1  input  ADDR_W  source register 1 address.
- READREG2  input  ADDR_W  source register 2 address.
- IMMEDIATE  input  WIDTH  immediate operand.
- IMM_SEL  input  1  1: source 2 = IMMEDIATE; 0: source 2 = register READREG2.
- NEG_SEL  input  1  1: DATA2 = two's complement of source 2.
- ALUOP  input  3  ALU select code, passed through unchanged.
- OUT_VALID  output  1  DATA1/DATA2/SELECT hold a valid operation.
- OUT_READY  input  1  ALU side consumes the operation.
- DATA1  output  WIDTH  registered operand 1.
- DATA2  output  WIDTH  registered operand 2.
- SELECT  output  3  registered ALU select.
- WRITEENABLE  input  1  write-back strobe.
- WRITEREG  input  ADDR_W  write-back register address.
- WRITEDATA  input  WIDTH  write-back data (ALU RESULT).

Behaviour:
- Reset (asynchronous, active-high):
  - All NREGS registers clear to 0.
  - OUT_VALID=0, DATA1=0, DATA2=0, SELECT=0.
  - IN_READY=1 while RESET is low and OUT_VALID=0.
  - Reset asserted mid-operation discards the held operation and any write in that cycle.
- Handshake:
  - IN_READY = !OUT_VALID || OUT_READY (combinational).
  - Accept occurs when IN_VALID && IN_READY at a clock edge.
  - Consume occurs when OUT_VALID && OUT_READY.
  - Simultaneous consume and accept in one edge: new operation is loaded and OUT_VALID stays 1 (full throughput, one op per cycle).
  - Consume without accept: OUT_VALID goes to 0.
  - While OUT_VALID && !OUT_READY: DATA1/DATA2/SELECT hold stable and IN_READY=0.
- Latency: accept at edge N, so the operation is visible on the outputs after edge N (one cycle).
- Operand formation (combinational, sampled at accept):
  - r1 = WRITEENABLE && WRITEREG==READREG1 ? WRITEDATA : reg[READREG1]. Same rule for r2 with READREG2 (write-first forwarding).
  - s2 = IMM_SEL ? IMMEDIATE : r2.
  - DATA2 <= NEG_SEL ? (~s2 + 1) mod 2^WIDTH : s2.
  - Negation wraps: 0x00 -> 0x00, 0x80 -> 0x80.
  - DATA1 <= r1; SELECT <= ALUOP.
- Register file:
  - When WRITEENABLE=1 at an edge (RESET low), reg[WRITEREG] <= WRITEDATA.
  - Writes happen independently of the handshake and are allowed even when IN_READY=0.
  - All NREGS registers are writable.
- Held operands are captured values. A write to a source register after accept does not alter DATA1/DATA2 while the operation is held.
- READREG1 == READREG2 is legal; both ports return the same value (forwarded if applicable).
- Inputs are ignored when IN_VALID=0; outputs do not change unless an accept occurs.

Test Plan:
- Reset then idle: assert RESET mid-run with OUT_VALID=1 -> OUT_VALID=0, DATA1=DATA2=SELECT=0 immediately; afterwards an issue of READREG1=5, READREG2=6 yields DATA1=0x00, DATA2=0x00.
- Write then read: write reg3=0x2A, reg4=0x05; issue READREG1=3, READREG2=4, ALUOP=001, OUT_READY=1 -> next cycle DATA1=0x2A, DATA2=0x05, SELECT=001, OUT_VALID=1.
- Immediate and negate:
  - reg1=0x10; issue IMM_SEL=1, IMMEDIATE=0x03, NEG_SEL=1 -> DATA2=0xFD.
  - IMMEDIATE=0x80, NEG_SEL=1 -> DATA2=0x80.
  - IMMEDIATE=0x00, NEG_SEL=1 -> DATA2=0x00.
- Forwarding: same cycle WRITEENABLE=1, WRITEREG=2, WRITEDATA=0x77 and issue READREG1=2, READREG2=2 -> DATA1=0x77, DATA2=0x77; reg2 reads 0x77 afterwards.
- Backpressure:
  - Hold OUT_READY=0 with OUT_VALID=1 -> IN_READY=0 and outputs stable for 5 cycles despite IN_VALID=1.
  - Write reg of held source during the stall -> DATA1 unchanged.
  - Raise OUT_READY -> held op consumed and pending op loaded on the same edge, OUT_VALID stays 1.
- Throughput: back-to-back issue of 4 ops with OUT_READY=1 -> 4 consecutive cycles of OUT_VALID=1 with the correct operands each cycle, no bubbles.
